fir_mac_sched: RTL

Time-multiplexed scheduler for one signed multiply-accumulate unit of a polyphase FIR sub-filter in the DWT path. It accepts one input sample per handshake and shifts it into a TAPS-deep delay line. It then sequences the shared MAC over the taps, one tap per cycle, and presents the finished output sample on a valid/ready port. Coefficients are loaded through a small write port, so one MAC replaces TAPS parallel multipliers.

---
 rtl/fir_sched_pkg.sv | 15 +
 rtl/fir_mac.sv | 34 +++
 rtl/fir_mac_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/fir_sched_pkg.sv
// Shared state encoding and default widths for the time-multiplexed FIR MAC scheduler.
package fir_sched_pkg;

    localparam int W_IN_DEF  = 5;
    localparam int C_IN_DEF  = 3;
    localparam int Y_OUT_DEF = 12;
    localparam int TAPS_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate: clr zeroes the accumulator, en adds coef*x.
module fir_mac
    import fir_sched_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int C_IN  = C_IN_DEF,
    parameter int Y_OUT = Y_OUT_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [C_IN-1:0]  coef,
    input  logic signed [W_IN-1:0]  x,
    output logic signed [Y_OUT-1:0] acc
);

    logic signed [W_IN+C_IN-1:0] prod;

    // Full-width signed product; the sized cast sign-extends it to the accumulator width.
    assign prod = coef * x;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + Y_OUT'(prod);
        end
    end

endmodule

// File: rtl/fir_mac_sched.sv
// Sample intake, delay line, coefficient file and FSM sharing one MAC across all taps.
module fir_mac_sched
    import fir_sched_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int C_IN  = C_IN_DEF,
    parameter int Y_OUT = Y_OUT_DEF,
    parameter int TAPS  = TAPS_DEF,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [W_IN-1:0]  s_data,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [C_IN-1:0]  coef_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [Y_OUT-1:0] m_data,
    output logic                    busy
);

    state_t state, state_nxt;
    logic [AW-1:0] k;
    logic signed [W_IN-1:0] x [TAPS];
    logic signed [C_IN-1:0] coef [TAPS];
    logic accept, last, coef_wr;

    assign s_ready = (state == ST_IDLE);
    assign m_valid = (state == ST_OUT);
    assign busy    = (state != ST_IDLE);
    assign accept  = s_valid && s_ready;
    assign last    = (state == ST_MAC) && (k == AW'(TAPS - 1));
    assign coef_wr = coef_we && (state == ST_IDLE) && (int'(coef_addr) < TAPS);

    // NOTE: next state gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)  state_nxt = ST_MAC;
            ST_MAC:  if (last)    state_nxt = ST_OUT;
            ST_OUT:  if (m_ready) state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                k <= '0;
            end else if (state == ST_MAC) begin
                k <= k + 1'b1;
            end
        end
    end

    // NOTE: the delay line and coefficient file are small register arrays, so they take the reset too.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i]    <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (coef_wr) begin
                coef[coef_addr] <= coef_data;
            end
            if (accept) begin
                x[0] <= s_data;
                for (int i = 1; i < TAPS; i++) begin
                    x[i] <= x[i-1];
                end
            end
        end
    end

    // The accumulator holds the finished sum through OUT, so it drives m_data directly.
    fir_mac #(
        .W_IN  (W_IN),
        .C_IN  (C_IN),
        .Y_OUT (Y_OUT)
    ) u_mac (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (state == ST_MAC),
        .coef (coef[k]),
        .x    (x[k]),
        .acc  (m_data)
    );

endmodule
